// File: rtl/integral_image_builder_pkg.sv
// Shared widths, default frame geometry and width helpers for the
// integral image stage.
package integral_image_builder_pkg;

    localparam int unsigned DEF_BYTE_WIDTH        = 8;
    localparam int unsigned DEF_BYTE_DOUBLE_WIDTH = 16;
    localparam int unsigned DEF_FRAME_WIDTH       = 10;
    localparam int unsigned DEF_FRAME_HEIGHT      = 10;
    localparam int unsigned DEF_INTEGRAL_WIDTH    = 16;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned n = 1; n < value; n = n << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0..value-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned value);
        return (clog2(value) == 0) ? 1 : clog2(value);
    endfunction

    // Smallest integral word that cannot overflow on a full frame of max pixels.
    function automatic int unsigned min_integral_width(input int unsigned byte_width,
                                                        input int unsigned frame_w,
                                                        input int unsigned frame_h);
        return byte_width + clog2(frame_w * frame_h);
    endfunction

endpackage

// File: rtl/integral_image_builder_line.sv
// One-row store of integral values: combinational read, synchronous write.
// A read and write to the same address on one edge returns the old contents.
module integral_line_buffer
    import integral_image_builder_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_FRAME_WIDTH,
    parameter int unsigned WIDTH      = DEF_INTEGRAL_WIDTH,
    parameter int unsigned ADDR_WIDTH = cnt_width(DEF_FRAME_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Write the new integral value over the previous row's entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/integral_image_builder.sv
// Integral image builder: consumes a raster-order pixel stream and emits
// ii(x,y) one cycle after each accepted pixel, with its coordinates.
module integral_image_builder
    import integral_image_builder_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH        = DEF_BYTE_WIDTH,
    parameter int unsigned BYTE_DOUBLE_WIDTH = DEF_BYTE_DOUBLE_WIDTH,
    parameter int unsigned FRAME_WIDTH       = DEF_FRAME_WIDTH,
    parameter int unsigned FRAME_HEIGHT      = DEF_FRAME_HEIGHT,
    parameter int unsigned INTEGRAL_WIDTH    = DEF_INTEGRAL_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_valid,
    input  logic                         i_sof,
    input  logic [BYTE_WIDTH-1:0]        i_pixel,
    output logic                         o_valid,
    output logic [INTEGRAL_WIDTH-1:0]    o_integral,
    output logic [BYTE_DOUBLE_WIDTH-1:0] o_xcoord,
    output logic [BYTE_DOUBLE_WIDTH-1:0] o_ycoord,
    output logic                         o_frame_done
);

    localparam int unsigned XW = cnt_width(FRAME_WIDTH);
    localparam int unsigned YW = cnt_width(FRAME_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    logic [XW-1:0]             x_cnt, x_cur, x_next;
    logic [YW-1:0]             y_cnt, y_cur, y_next;
    logic [INTEGRAL_WIDTH-1:0] acc, rowsum, above, ii, line_rd;
    logic                      last_pixel, line_we;

    // Resolve the current pixel position, its integral value and the next position.
    always_comb begin
        x_cur      = i_sof ? '0 : x_cnt;
        y_cur      = i_sof ? '0 : y_cnt;
        rowsum     = ((x_cur == '0) ? '0 : acc) + INTEGRAL_WIDTH'(i_pixel);
        above      = (y_cur == '0) ? '0 : line_rd;
        ii         = rowsum + above;
        last_pixel = (x_cur == X_LAST) && (y_cur == Y_LAST);
        line_we    = i_valid && reset_n;
        x_next     = x_cur + XW'(1);
        y_next     = y_cur;
        if (x_cur == X_LAST) begin
            x_next = '0;
            y_next = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
        end
    end

    integral_line_buffer #(
        .DEPTH      (FRAME_WIDTH),
        .WIDTH      (INTEGRAL_WIDTH),
        .ADDR_WIDTH (XW)
    ) u_line (
        .clk     (clk),
        .wr_en   (line_we),
        .addr    (x_cur),
        .wr_data (ii),
        .rd_data (line_rd)
    );

    // Advance coordinates and row accumulator, and register the outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_cnt        <= '0;
            y_cnt        <= '0;
            acc          <= '0;
            o_valid      <= 1'b0;
            o_integral   <= '0;
            o_xcoord     <= '0;
            o_ycoord     <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= i_valid;
            o_frame_done <= i_valid && last_pixel;
            if (i_valid) begin
                x_cnt      <= x_next;
                y_cnt      <= y_next;
                acc        <= rowsum;
                o_integral <= ii;
                o_xcoord   <= BYTE_DOUBLE_WIDTH'(x_cur);
                o_ycoord   <= BYTE_DOUBLE_WIDTH'(y_cur);
            end
        end
    end

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder: a vector table for the first
// row of a frame, then hand-written sequences checked against a
// direct-summation reference image.
module tb_integral_image_builder;

    localparam int FW = 10;
    localparam int FH = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid;
    logic        i_sof;
    logic [7:0]  i_pixel;
    logic        o_valid;
    logic [15:0] o_integral;
    logic [15:0] o_xcoord;
    logic [15:0] o_ycoord;
    logic        o_frame_done;

    integral_image_builder #(
        .BYTE_WIDTH        (8),
        .BYTE_DOUBLE_WIDTH (16),
        .FRAME_WIDTH       (FW),
        .FRAME_HEIGHT      (FH),
        .INTEGRAL_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_pixel      (i_pixel),
        .o_valid      (o_valid),
        .o_integral   (o_integral),
        .o_xcoord     (o_xcoord),
        .o_ycoord     (o_ycoord),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference image, current model position and held output values.
    int img [FH][FW];
    int mx = 0, my = 0;
    int h_ii = 0, h_x = 0, h_y = 0;

    typedef struct {
        bit v; bit sof; int pix;
        bit ev; int eii; int ex; int ey; bit ed;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept one pixel into the reference image and return ii by direct summation.
    task automatic model_accept(input int pix, input bit sof,
                                output int eii, output int ex, output int ey, output bit ed);
        int s;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = pix & 255;
        s = 0;
        for (int j = 0; j <= my; j++)
            for (int i = 0; i <= mx; i++)
                s += img[j][i];
        eii = s & 16'hFFFF;
        ex  = mx;
        ey  = my;
        ed  = (mx == FW - 1) && (my == FH - 1);
        if (mx == FW - 1) begin
            mx = 0;
            my = (my == FH - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    // One clock with the given inputs; outputs compared 1 time unit after the edge.
    task automatic cycle(input bit v, input bit sof, input int pix);
        int eii, ex, ey;
        bit ed;
        ed = 1'b0;
        i_valid = v;
        i_sof   = sof;
        i_pixel = 8'(pix);
        if (v) begin
            model_accept(pix, sof, eii, ex, ey, ed);
            h_ii = eii; h_x = ex; h_y = ey;
        end
        @(posedge clk);
        #1;
        chk("valid",      32'(o_valid),      32'(v));
        chk("integral",   32'(o_integral),   h_ii);
        chk("xcoord",     32'(o_xcoord),     h_x);
        chk("ycoord",     32'(o_ycoord),     h_y);
        chk("frame_done", 32'(o_frame_done), 32'(ed));
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    // One cycle of reset (inputs left as given) and check the cleared outputs.
    task automatic do_reset(input bit v, input int pix);
        reset_n = 1'b0;
        i_valid = v;
        i_sof   = 1'b0;
        i_pixel = 8'(pix);
        @(posedge clk);
        #1;
        chk("rst_valid",    32'(o_valid),      0);
        chk("rst_integral", 32'(o_integral),   0);
        chk("rst_xcoord",   32'(o_xcoord),     0);
        chk("rst_ycoord",   32'(o_ycoord),     0);
        chk("rst_done",     32'(o_frame_done), 0);
        mx = 0; my = 0; h_ii = 0; h_x = 0; h_y = 0;
        reset_n = 1'b1;
        i_valid = 1'b0;
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_pixel = '0;

        // Table: incrementing pixels, row 0 prefix sums, a bubble, start of row 1.
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 1'b0, i, 1'b1, (i * (i + 1)) / 2, i, 0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 0,  1'b0, 45, 9, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 10, 1'b1, 10, 0, 1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 11, 1'b1, 22, 1, 1, 1'b0};

        do_reset(1'b0, 0);

        for (int t = 0; t < 13; t++) begin
            int eii, ex, ey;
            bit ed;
            i_valid = tbl[t].v;
            i_sof   = tbl[t].sof;
            i_pixel = 8'(tbl[t].pix);
            if (tbl[t].v) begin
                model_accept(tbl[t].pix, tbl[t].sof, eii, ex, ey, ed);
                h_ii = eii; h_x = ex; h_y = ey;
            end
            @(posedge clk);
            #1;
            chk("tbl_valid",    32'(o_valid),      32'(tbl[t].ev));
            chk("tbl_integral", 32'(o_integral),   tbl[t].eii);
            chk("tbl_xcoord",   32'(o_xcoord),     tbl[t].ex);
            chk("tbl_ycoord",   32'(o_ycoord),     tbl[t].ey);
            chk("tbl_done",     32'(o_frame_done), 32'(tbl[t].ed));
            i_valid = 1'b0;
        end
        // Rest of the incrementing frame.
        for (int n = 12; n < FW * FH; n++)
            cycle(1'b1, 1'b0, n & 255);

        // All-ones frame: ii = (x+1)*(y+1).
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
                cycle(1'b1, 1'b0, 1);
                chk("ones_formula", 32'(o_integral), (x + 1) * (y + 1));
            end

        // Two back-to-back all-255 frames; corner must be 25500 both times.
        for (int f = 0; f < 2; f++)
            for (int n = 0; n < FW * FH; n++) begin
                cycle(1'b1, 1'b0, 255);
                if (n == FW * FH - 1) begin
                    chk("max_corner", 32'(o_integral), 25500);
                    chk("max_done",   32'(o_frame_done), 1);
                end
            end

        // Incrementing frame with random bubbles.
        k = 0;
        while (k < FW * FH) begin
            if ($urandom_range(1, 0) == 0) begin
                cycle(1'b0, 1'b0, 0);
            end else begin
                cycle(1'b1, 1'b0, k & 255);
                k++;
            end
        end

        // Mid-frame start-of-frame at (4,3).
        for (int n = 0; n < 3 * FW + 4; n++)
            cycle(1'b1, 1'b0, ((n % FW) * 7 + (n / FW) * 3) & 255);
        cycle(1'b1, 1'b1, 99);
        chk("sof_x",  32'(o_xcoord),   0);
        chk("sof_y",  32'(o_ycoord),   0);
        chk("sof_ii", 32'(o_integral), 99);
        for (int n = 1; n < FW * FH; n++)
            cycle(1'b1, 1'b0, (n * 13 + 5) & 255);

        // Reset while pixel (6,5) is presented.
        for (int n = 0; n < 5 * FW + 6; n++)
            cycle(1'b1, 1'b0, (n * 11 + 1) & 255);
        do_reset(1'b1, 200);
        cycle(1'b1, 1'b0, 77);
        chk("post_rst_x",  32'(o_xcoord),   0);
        chk("post_rst_y",  32'(o_ycoord),   0);
        chk("post_rst_ii", 32'(o_integral), 77);
        for (int n = 1; n < FW * FH; n++)
            cycle(1'b1, 1'b0, (n * 29 + 3) & 255);

        // Frame whose first pixel carries i_sof (no-op at (0,0)).
        cycle(1'b1, 1'b1, 5);
        for (int n = 1; n < FW * FH; n++)
            cycle(1'b1, 1'b0, (n * 3) & 255);
        cycle(1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/integral_image_builder.md
Name: integral_image_builder

Overview:
Stage directly downstream of the pixel line-buffer (ram_memory) in the face-detection pipeline. Consumes the raster-order 8-bit pixel stream, tracks frame coordinates internally and produces the integral image ii(x,y) = sum of all pixels p(i,j) with i<=x, j<=y, one value per accepted pixel. Haar feature evaluation downstream reads rectangle sums from these values.

Parameters:
BYTE_WIDTH, 8, pixel width
BYTE_DOUBLE_WIDTH, 16, coordinate output width
FRAME_WIDTH, 10, pixels per row
FRAME_HEIGHT, 10, rows per frame
INTEGRAL_WIDTH, 16, integral word width; must be >= BYTE_WIDTH + clog2(FRAME_WIDTH*FRAME_HEIGHT); default holds 255*100 = 25500

Ports:
clk  in  1  single clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
i_valid  in  1  pixel qualifier; pixel accepted on posedge clk when high
i_sof  in  1  start-of-frame marker, sampled only when i_valid=1
i_pixel  in  BYTE_WIDTH  unsigned pixel
o_valid  out  1  integral output qualifier
o_integral  out  INTEGRAL_WIDTH  ii at (o_xcoord, o_ycoord)
o_xcoord  out  BYTE_DOUBLE_WIDTH  column of o_integral
o_ycoord  out  BYTE_DOUBLE_WIDTH  row of o_integral
o_frame_done  out  1  one-cycle pulse, coincident with o_valid for pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1)

Behaviour:
- Reset (reset_n=0 at posedge): o_valid=0, o_integral=0, o_xcoord=0, o_ycoord=0, o_frame_done=0, x/y counters=0, row accumulator=0. Line-buffer contents are not cleared; row 0 never reads them.
- Reset applied mid-frame discards the partial frame; the next accepted pixel is (0,0) regardless of i_sof.
- No backpressure; i_valid may drop for any number of cycles; with i_valid=0, counters, accumulator and line buffer hold and o_valid=0 next cycle (o_integral/coords hold last value).
- Latency: exactly 1 cycle, pixel accepted at edge N -> o_valid=1 with its result after edge N.
- Per accepted pixel at (x,y): rowsum = (x==0 ? 0 : acc) + i_pixel; above = (y==0 ? 0 : line[x]); ii = rowsum + above. Registered: o_integral<=ii, acc<=rowsum, line[x]<=ii, o_xcoord<=x, o_ycoord<=y.
- Read of line[x] sees the previous row's value (read-before-write on same address, same edge).
- Arithmetic unsigned, zero-extended; results truncated modulo 2^INTEGRAL_WIDTH (no saturation, no flag).
- Coordinate advance: x==FRAME_WIDTH-1 -> x=0 and y increments, or wraps to 0 if y==FRAME_HEIGHT-1; otherwise x increments.
- i_sof=1 with i_valid=1: that pixel is treated as (0,0) whatever the counters hold, and counters continue from (1,0). i_sof at (0,0) is a no-op.
- o_frame_done=1 only for the last pixel of a frame; the next frame starts automatically at (0,0) with no idle cycle required.

Decomposition:
- Shared package: BYTE_WIDTH, BYTE_DOUBLE_WIDTH, default FRAME_WIDTH/FRAME_HEIGHT, INTEGRAL_WIDTH, and a clog2 helper for width checks.
- One sub-module: integral_line_buffer, FRAME_WIDTH x INTEGRAL_WIDTH register array, combinational read, synchronous write, read-before-write on the same address.
- Coordinate counter and accumulator stay in the top level.

Test Plan:
- All pixels=1, 10x10, i_valid always 1 -> o_integral=(x+1)*(y+1); (9,9)=100 with o_frame_done=1, only on that cycle.
- Incrementing pixel 0,1,2,... (wrap at 255) -> row 0 outputs 0,1,3,6,10,15,21,28,36,45; (0,1)=10; whole frame matches golden model.
- All pixels=255 -> (9,9)=25500; two back-to-back frames give identical results (no carry-over between frames).
- Pseudo-random i_valid gaps (~50% duty) -> same value sequence as gap-free run; o_valid low on every bubble cycle; 1-cycle latency holds.
- i_sof asserted at (4,3) mid-frame -> that pixel reported as (0,0); following outputs equal a fresh frame from that point.
- reset_n low for 1 cycle at (6,5) -> all outputs 0 next cycle; next accepted pixel reported at (0,0) with ii=pixel value.
